psum_tile_writeback: RTL and testbench

- Parametrised successor to the core's fixed 64-vector PSUM write counter.
- Drains OFIFO output vectors into the PSUM SRAM over a run of tiles. Tile length, tile count and base address are programmable.
- Two modes: overwrite (one vector per cycle) and accumulate (read-modify-write, lane-wise add into the existing PSUM).
- Sits between the corelet OFIFO and the PSUM SRAM port. Emits per-tile and end-of-run pulses that the SFP load logic consumes.

---
 rtl/psum_tile_writeback.sv | 185 ++++++++++++++++++
 tb/tb_psum_tile_writeback.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_tile_writeback.sv
// psum_tile_writeback: drains OFIFO vectors into the PSUM SRAM across a run of
// tiles, either overwriting (1 vector/cycle) or accumulating via read-modify-write
// (1 vector/2 cycles). Emits tile_done / all_done pulses for the SFP load logic.
// Build option: define PSUM_SAT_EN to make the accumulate lane add saturate
// instead of wrapping.
//
// state | meaning
// IDLE  | waiting for a start with non-zero tile length and tile count
// WR    | overwrite: pop OFIFO head and write it at the current address
// RD    | accumulate: pop OFIFO head, latch it, read existing PSUM at address
// ACC   | accumulate: write lane-wise sum of read data and latched vector
// FIN   | one cycle after the last write; drops busy, returns to IDLE
module psum_tile_writeback #(
  parameter int psum_bw   = 16,
  parameter int col       = 8,
  parameter int ADD_WIDTH = 11,
  parameter int CNT_W     = 7,
  parameter int TILE_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     acc_en,
  input  logic [ADD_WIDTH-1:0]     base_addr,
  input  logic [CNT_W-1:0]         tile_len,
  input  logic [TILE_W-1:0]        num_tiles,
  input  logic                     ofifo_valid,
  input  logic [col*psum_bw-1:0]   ofifo_data,
  output logic                     ofifo_rd,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [ADD_WIDTH-1:0]     sram_addr,
  output logic [col*psum_bw-1:0]   sram_d,
  input  logic [col*psum_bw-1:0]   sram_q,
  output logic                     tile_done,
  output logic                     all_done,
  output logic                     busy,
  output logic [TILE_W-1:0]        tile_idx
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_ACC, S_FIN} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [ADD_WIDTH-1:0]     r_addr;
  logic [CNT_W-1:0]         r_vec_cnt;
  logic [CNT_W-1:0]         r_tile_len;
  logic [TILE_W-1:0]        r_num_tiles;
  logic [TILE_W-1:0]        r_tile_idx;
  logic [col*psum_bw-1:0]   r_vec;
  logic                     r_tile_done;
  logic                     r_all_done;
  logic                     r_busy;

  logic                     w_start_ok;
  logic                     w_commit;
  logic                     w_last_vec;
  logic                     w_last_tile;
  logic [col*psum_bw-1:0]   w_acc_sum;

  assign w_start_ok  = start && (tile_len != '0) && (num_tiles != '0);
  assign w_last_vec  = (r_vec_cnt == r_tile_len - CNT_W'(1));
  assign w_last_tile = (r_tile_idx == r_num_tiles - TILE_W'(1));

  assign tile_done = r_tile_done;
  assign all_done  = r_all_done;
  assign busy      = r_busy;
  assign tile_idx  = r_tile_idx;

`ifdef PSUM_SAT_EN
  logic [psum_bw:0] w_lane_ext;

  // Lane-wise signed add of read PSUM and latched vector, clamped on overflow.
  always_comb begin
    w_acc_sum  = '0;
    w_lane_ext = '0;
    for (int l = 0; l < col; l++) begin
      w_lane_ext = {sram_q[l*psum_bw+psum_bw-1], sram_q[l*psum_bw +: psum_bw]} +
                   {r_vec[l*psum_bw+psum_bw-1],  r_vec[l*psum_bw +: psum_bw]};
      if (w_lane_ext[psum_bw] != w_lane_ext[psum_bw-1])
        w_acc_sum[l*psum_bw +: psum_bw] = w_lane_ext[psum_bw] ?
            {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      else
        w_acc_sum[l*psum_bw +: psum_bw] = w_lane_ext[psum_bw-1:0];
    end
  end
`else
  // Lane-wise add of read PSUM and latched vector, carry discarded per lane.
  always_comb begin
    w_acc_sum = '0;
    for (int l = 0; l < col; l++)
      w_acc_sum[l*psum_bw +: psum_bw] = sram_q[l*psum_bw +: psum_bw] +
                                        r_vec[l*psum_bw +: psum_bw];
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and SRAM/OFIFO handshake; outputs are idle unless a transfer happens.
  always_comb begin
    w_next    = r_state;
    ofifo_rd  = 1'b0;
    sram_cen  = 1'b1;
    sram_wen  = 1'b1;
    sram_addr = '0;
    sram_d    = '0;
    w_commit  = 1'b0;
    case (r_state)
      S_IDLE: if (w_start_ok) w_next = acc_en ? S_RD : S_WR;
      S_WR: begin
        if (ofifo_valid) begin
          ofifo_rd  = 1'b1;
          sram_cen  = 1'b0;
          sram_wen  = 1'b0;
          sram_addr = r_addr;
          sram_d    = ofifo_data;
          w_commit  = 1'b1;
          if (w_last_vec && w_last_tile) w_next = S_FIN;
        end
      end
      S_RD: begin
        if (ofifo_valid) begin
          ofifo_rd  = 1'b1;
          sram_cen  = 1'b0;
          sram_addr = r_addr;
          w_next    = S_ACC;
        end
      end
      S_ACC: begin
        sram_cen  = 1'b0;
        sram_wen  = 1'b0;
        sram_addr = r_addr;
        sram_d    = w_acc_sum;
        w_commit  = 1'b1;
        w_next    = (w_last_vec && w_last_tile) ? S_FIN : S_RD;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Run config, address/vector/tile counters, busy flag and done pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr      <= '0;
      r_vec_cnt   <= '0;
      r_tile_len  <= '0;
      r_num_tiles <= '0;
      r_tile_idx  <= '0;
      r_vec       <= '0;
      r_tile_done <= 1'b0;
      r_all_done  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_tile_done <= 1'b0;
      r_all_done  <= 1'b0;
      if (r_state == S_IDLE && w_start_ok) begin
        r_tile_len  <= tile_len;
        r_num_tiles <= num_tiles;
        r_addr      <= base_addr;
        r_vec_cnt   <= '0;
        r_tile_idx  <= '0;
        r_busy      <= 1'b1;
      end
      if (r_state == S_FIN) r_busy <= 1'b0;
      if (r_state == S_RD && ofifo_valid) r_vec <= ofifo_data;
      if (w_commit) begin
        r_addr <= r_addr + ADD_WIDTH'(1);
        if (w_last_vec) begin
          r_vec_cnt   <= '0;
          r_tile_done <= 1'b1;
          if (w_last_tile) r_all_done <= 1'b1;
          else             r_tile_idx <= r_tile_idx + TILE_W'(1);
        end else begin
          r_vec_cnt <= r_vec_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_tile_writeback.sv
// Directed bench for psum_tile_writeback with an SRAM model and a write scoreboard.
module tb_psum_tile_writeback;
  localparam int PBW = 16;
  localparam int COL = 8;
  localparam int AW  = 11;
  localparam int CW  = 7;
  localparam int TW  = 8;
  localparam int DW  = PBW * COL;
`ifdef PSUM_SAT_EN
  localparam logic [PBW-1:0] EXP_OVF_POS = 16'h7FFF;
  localparam logic [PBW-1:0] EXP_OVF_NEG = 16'h8000;
`else
  localparam logic [PBW-1:0] EXP_OVF_POS = 16'h8000;
  localparam logic [PBW-1:0] EXP_OVF_NEG = 16'h7FFF;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, acc_en, ofifo_valid;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] tile_len;
  logic [TW-1:0] num_tiles;
  logic [DW-1:0] ofifo_data, sram_q, sram_d;
  logic          ofifo_rd, sram_cen, sram_wen, tile_done, all_done, busy;
  logic [AW-1:0] sram_addr;
  logic [TW-1:0] tile_idx;

  psum_tile_writeback #(.psum_bw(PBW), .col(COL), .ADD_WIDTH(AW), .CNT_W(CW), .TILE_W(TW)) dut (
    .clk(clk), .reset(reset), .start(start), .acc_en(acc_en), .base_addr(base_addr),
    .tile_len(tile_len), .num_tiles(num_tiles), .ofifo_valid(ofifo_valid),
    .ofifo_data(ofifo_data), .ofifo_rd(ofifo_rd), .sram_cen(sram_cen), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_d(sram_d), .sram_q(sram_q), .tile_done(tile_done),
    .all_done(all_done), .busy(busy), .tile_idx(tile_idx));

  // SRAM model: synchronous write, read data registered one cycle after the read.
  logic [DW-1:0] mem [0:2047];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (!sram_cen) begin
      if (!sram_wen) mem[sram_addr] <= sram_d;
      else           sram_q <= mem[sram_addr];
    end
  end

  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t           exp_q[$];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] mirror [0:2047];

  int            n_assert = 0, n_fail = 0;
  int            n_writes, n_reads, n_pops, n_cycles;
  int            td_at[$];
  bit            saw_all, last_busy, chk_stall;
  logic [TW-1:0] last_idx;
  logic [AW-1:0] last_rd_addr;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    int s;
    r = '0;
    for (int l = 0; l < COL; l++) begin
      s = int'($signed(a[l*PBW +: PBW])) + int'($signed(b[l*PBW +: PBW]));
`ifdef PSUM_SAT_EN
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
`endif
      r[l*PBW +: PBW] = s[PBW-1:0];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_ow(input logic [AW-1:0] a, input logic [DW-1:0] v);
    fq.push_back(v);
    exp_q.push_back('{a: a, d: v});
    mirror[a] = v;
  endtask

  task automatic push_acc(input logic [AW-1:0] a, input logic [DW-1:0] v);
    logic [DW-1:0] n;
    n = lane_add(mirror[a], v);
    mirror[a] = n;
    fq.push_back(v);
    exp_q.push_back('{a: a, d: n});
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    pre_addr = a; pre_data = v; pre_en = 1'b1; mirror[a] = v;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // One clock: drive OFIFO at posedge+1, observe everything at negedge.
  task automatic cycle(input bit v);
    bit popped;
    wr_t w;
    ofifo_valid = v && (fq.size() != 0);
    ofifo_data  = (fq.size() != 0) ? fq[0] : '0;
    @(negedge clk);
    n_cycles++;
    last_busy = busy;
    last_idx  = tile_idx;
    if (tile_done) td_at.push_back(n_writes);
    if (all_done) begin
      saw_all = 1'b1;
      chk("all_done_with_tile_done", tile_done, 1);
    end
    if (!ofifo_valid) chk("no_pop_without_valid", ofifo_rd, 0);
    if (chk_stall && !ofifo_valid) chk("stall_sram_idle", sram_cen, 1);
    if (ofifo_rd) n_pops++;
    if (!sram_cen && sram_wen) begin n_reads++; last_rd_addr = sram_addr; end
    if (!sram_cen && !sram_wen) begin
      n_writes++;
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: addr %0h with no expected write pending", sram_addr);
      end
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("write_addr", sram_addr, w.a);
        chk("write_data", sram_d, w.d);
      end
    end
    popped = ofifo_rd;
    @(posedge clk); #1;
    if (popped && fq.size() != 0) fq.delete(0);
  endtask

  task automatic do_start(input bit acc, input logic [AW-1:0] b, input logic [CW-1:0] len,
                          input logic [TW-1:0] nt);
    td_at.delete();
    saw_all = 1'b0; n_writes = 0; n_reads = 0; n_pops = 0;
    acc_en = acc; base_addr = b; tile_len = len; num_tiles = nt; start = 1'b1;
    cycle(0);
    start = 1'b0;
    n_cycles = 0;
  endtask

  task automatic run(input int max_cyc);
    int k = 0;
    while (!saw_all && k < max_cyc) begin cycle(1); k++; end
    n_assert++;
    assert (saw_all) else begin
      n_fail++;
      $error("FAIL run_timeout: all_done not seen within %0d cycles", max_cyc);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_ofifo_rd"},  ofifo_rd, 0);
    chk({pfx, "_sram_cen"},  sram_cen, 1);
    chk({pfx, "_sram_wen"},  sram_wen, 1);
    chk({pfx, "_sram_addr"}, sram_addr, 0);
    chk({pfx, "_sram_d"},    sram_d, 0);
    chk({pfx, "_tile_done"}, tile_done, 0);
    chk({pfx, "_all_done"},  all_done, 0);
    chk({pfx, "_busy"},      busy, 0);
    chk({pfx, "_tile_idx"},  tile_idx, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [DW-1:0] v0, v1;
    reset = 1'b0; start = 1'b0; acc_en = 1'b0; base_addr = '0; tile_len = '0; num_tiles = '0;
    ofifo_valid = 1'b0; ofifo_data = '0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    chk_stall = 1'b0; sram_q = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Overwrite, 2 tiles x 4 vectors, OFIFO always valid.
    for (int i = 0; i < 8; i++) push_ow(AW'(11'h010 + i), rnd_vec());
    do_start(0, 11'h010, 4, 2);
    run(30);
    chk("ow_latency", n_cycles, 9);
    chk("ow_writes", n_writes, 8);
    chk("ow_pops", n_pops, 8);
    chk("ow_tile_done_count", td_at.size(), 2);
    if (td_at.size() == 2) begin
      chk("ow_tile_done_first", td_at[0], 4);
      chk("ow_tile_done_second", td_at[1], 8);
    end
    chk("ow_tile_idx_at_end", last_idx, 1);
    chk("ow_busy_with_all_done", last_busy, 1);
    chk("ow_scoreboard_empty", exp_q.size(), 0);
    cycle(0);
    chk("ow_busy_after", last_busy, 0);

    // Accumulate, single vector: 5 + 3 per lane.
    preload(11'h020, {COL{16'd5}});
    push_acc(11'h020, {COL{16'd3}});
    do_start(1, 11'h020, 1, 1);
    run(10);
    chk("acc_latency", n_cycles, 3);
    chk("acc_reads", n_reads, 1);
    chk("acc_read_addr", last_rd_addr, 11'h020);
    chk("acc_pops", n_pops, 1);
    chk("acc_writes", n_writes, 1);
    chk("acc_mem", mem[11'h020], {COL{16'd8}});
    cycle(0);

    // Accumulate overflow in both directions, plus a second random vector.
    v0 = rnd_vec();
    v0[15:0] = 16'h7FFF; v0[31:16] = 16'h8000;
    v1 = rnd_vec();
    v1[15:0] = 16'h0001; v1[31:16] = 16'hFFFF;
    preload(11'h030, v0);
    preload(11'h031, rnd_vec());
    push_acc(11'h030, v1);
    push_acc(11'h031, rnd_vec());
    do_start(1, 11'h030, 2, 1);
    run(20);
    chk("ovf_latency", n_cycles, 5);
    chk("ovf_writes", n_writes, 2);
    v0 = mem[11'h030];
    chk("ovf_lane_pos", v0[15:0], EXP_OVF_POS);
    chk("ovf_lane_neg", v0[31:16], EXP_OVF_NEG);
    cycle(0);

    // Overwrite with OFIFO backpressure.
    for (int i = 0; i < 5; i++) push_ow(AW'(11'h100 + i), rnd_vec());
    do_start(0, 11'h100, 5, 1);
    chk_stall = 1'b1;
    cycle(1); cycle(0); cycle(0); cycle(1); cycle(1); cycle(0); cycle(1); cycle(1);
    run(10);
    chk_stall = 1'b0;
    chk("stall_latency", n_cycles, 9);
    chk("stall_writes", n_writes, 5);
    chk("stall_pops", n_pops, 5);
    chk("stall_tile_done_count", td_at.size(), 1);
    if (td_at.size() == 1) chk("stall_tile_done_pos", td_at[0], 5);
    cycle(0);

    // Address wrap at the top of the SRAM.
    for (int i = 0; i < 4; i++) push_ow(AW'(11'h7FE + i), rnd_vec());
    do_start(0, 11'h7FE, 4, 1);
    run(20);
    chk("wrap_writes", n_writes, 4);
    chk("wrap_scoreboard_empty", exp_q.size(), 0);
    cycle(0);

    // Zero tile length / zero tile count: start must be ignored.
    fq.push_back(rnd_vec());
    do_start(0, 11'h050, 0, 3);
    repeat (3) cycle(1);
    chk("zero_len_busy", last_busy, 0);
    chk("zero_len_writes", n_writes, 0);
    chk("zero_len_pops", n_pops, 0);
    do_start(0, 11'h050, 4, 0);
    repeat (3) cycle(1);
    chk("zero_tiles_busy", last_busy, 0);
    chk("zero_tiles_writes", n_writes + n_reads, 0);
    fq.delete();

    // Start while busy ignored; reset mid-run after 2 of 4 writes.
    for (int i = 0; i < 4; i++) push_ow(AW'(11'h200 + i), rnd_vec());
    do_start(0, 11'h200, 4, 1);
    cycle(1);
    base_addr = 11'h300; tile_len = 1; num_tiles = 1; acc_en = 1'b1; start = 1'b1;
    cycle(1);
    start = 1'b0;
    chk("busy_start_writes", n_writes, 2);
    chk("busy_start_no_tile_done", td_at.size(), 0);
    ofifo_valid = (fq.size() != 0);
    reset = 1'b0;
    #1;
    chk_reset_outputs("midrun_reset");
    exp_q.delete();
    fq.delete();
    ofifo_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push_ow(AW'(11'h400 + i), rnd_vec());
    do_start(0, 11'h400, 3, 1);
    run(20);
    chk("rerun_latency", n_cycles, 4);
    chk("rerun_writes", n_writes, 3);
    chk("rerun_tile_done_count", td_at.size(), 1);
    if (td_at.size() == 1) chk("rerun_tile_done_pos", td_at[0], 3);
    chk("rerun_tile_idx", last_idx, 0);
    chk("rerun_scoreboard_empty", exp_q.size(), 0);
    cycle(0);
    chk("rerun_busy_after", last_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
